// File: rtl/ram_arb_pkg.sv
// rtl/ram_arb_pkg.sv - shared types and defaults for the two-port RAM arbiter
//
// Purpose: default RAM geometry, requester ids and the request record used by
//          ram_arbiter and rr_arbiter_2.
// Ports:   none (package)
package ram_arb_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 8;

  typedef enum logic {
    REQ_A = 1'b0,
    REQ_B = 1'b1
  } req_id_e;

  typedef struct packed {
    logic [ADDR_W_DEF-1:0] addr;
    logic [DATA_W_DEF-1:0] data;
    logic                  write;
  } ram_req_t;

  // Map a 2-bit one-hot grant to the requester id (B only when bit 1 is set).
  function automatic req_id_e gnt_to_id(input logic [1:0] gnt);
    return gnt[1] ? REQ_B : REQ_A;
  endfunction

endpackage

// File: rtl/rr_arbiter_2.sv
// rtl/rr_arbiter_2.sv - two-requester arbiter, round-robin or fixed priority
//
// Purpose: picks at most one of two requests per cycle.
// Ports:
//   i_clk    clock
//   i_rst    synchronous active-high reset (forces grant to 0, pointer to A)
//   i_req    request bits, [0] = A, [1] = B
//   o_gnt    one-hot grant (combinational)
module rr_arbiter_2 #(
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [1:0] i_req,
  output logic [1:0] o_gnt
);

  // ptr_q names the favoured requester on contention: 0 = A, 1 = B.
  logic ptr_q, ptr_d;

  always_comb begin
    o_gnt = 2'b00;
    ptr_d = ptr_q;
    if (!i_rst) begin
      if (i_req == 2'b11) begin
        // Contended: winner by pointer (or A when fixed), pointer moves to loser.
        if (FIXED_PRIO || !ptr_q) begin
          o_gnt = 2'b01;
          ptr_d = 1'b1;
        end else begin
          o_gnt = 2'b10;
          ptr_d = 1'b0;
        end
      end else begin
        o_gnt = i_req;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// rtl/ram_arbiter.sv - shares one single-port RAM between fetch (A) and load/store (B)
//
// Purpose: grants one requester per cycle onto the RAM port and routes the
//          one-cycle-late read data back to the requester that issued the read.
// Ports:
//   i_clk, i_rst                       clock, synchronous active-high reset
//   i_a_* / i_b_*                      requester address, write data, write, valid
//   o_a_ready / o_b_ready              request accepted this cycle
//   o_a_rsp_data / o_b_rsp_data        read data (held between responses)
//   o_a_rsp_valid / o_b_rsp_valid      one-cycle read data valid
//   o_ram_addr/data/write/valid        RAM request port
//   i_ram_rsp_data                     RAM registered read data
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int FIXED_PRIO = 0
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [ADDR_W-1:0] i_a_addr,
  input  logic [DATA_W-1:0] i_a_data,
  input  logic              i_a_write,
  input  logic              i_a_valid,
  output logic              o_a_ready,
  output logic [DATA_W-1:0] o_a_rsp_data,
  output logic              o_a_rsp_valid,
  input  logic [ADDR_W-1:0] i_b_addr,
  input  logic [DATA_W-1:0] i_b_data,
  input  logic              i_b_write,
  input  logic              i_b_valid,
  output logic              o_b_ready,
  output logic [DATA_W-1:0] o_b_rsp_data,
  output logic              o_b_rsp_valid,
  output logic [ADDR_W-1:0] o_ram_addr,
  output logic [DATA_W-1:0] o_ram_data,
  output logic              o_ram_write,
  output logic              o_ram_valid,
  input  logic [DATA_W-1:0] i_ram_rsp_data
);

  logic [1:0]        gnt;
  logic              pend_valid_q, pend_valid_d;
  req_id_e           pend_id_q, pend_id_d;
  logic [DATA_W-1:0] a_data_q, b_data_q;
  logic              a_hit, b_hit;

  rr_arbiter_2 #(
    .FIXED_PRIO (FIXED_PRIO != 0)
  ) u_arb (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_req ({i_b_valid, i_a_valid}),
    .o_gnt (gnt)
  );

  assign o_a_ready   = gnt[0];
  assign o_b_ready   = gnt[1];
  assign o_ram_valid = |gnt;

  always_comb begin
    o_ram_addr  = '0;
    o_ram_data  = '0;
    o_ram_write = 1'b0;
    if (gnt[0]) begin
      o_ram_addr  = i_a_addr;
      o_ram_data  = i_a_data;
      o_ram_write = i_a_write;
    end else if (gnt[1]) begin
      o_ram_addr  = i_b_addr;
      o_ram_data  = i_b_data;
      o_ram_write = i_b_write;
    end
  end

  // Only reads leave a response pending; writes complete in the grant cycle.
  assign pend_valid_d = o_ram_valid & ~o_ram_write;
  assign pend_id_d    = gnt_to_id(gnt);

  assign a_hit = ~i_rst & pend_valid_q & (pend_id_q == REQ_A);
  assign b_hit = ~i_rst & pend_valid_q & (pend_id_q == REQ_B);

  assign o_a_rsp_valid = a_hit;
  assign o_b_rsp_valid = b_hit;

  // RAM data is forwarded in the response cycle and captured so it holds afterwards.
  assign o_a_rsp_data = i_rst ? '0 : (a_hit ? i_ram_rsp_data : a_data_q);
  assign o_b_rsp_data = i_rst ? '0 : (b_hit ? i_ram_rsp_data : b_data_q);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      pend_valid_q <= 1'b0;
      pend_id_q    <= REQ_A;
      a_data_q     <= '0;
      b_data_q     <= '0;
    end else begin
      pend_valid_q <= pend_valid_d;
      pend_id_q    <= pend_id_d;
      if (a_hit) a_data_q <= i_ram_rsp_data;
      if (b_hit) b_data_q <= i_ram_rsp_data;
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// tb/tb_ram_arbiter.sv - self-checking bench for ram_arbiter
module tb_ram_arbiter;

  logic       clk;
  logic       rst;
  logic [7:0] a_addr, a_data, b_addr, b_data;
  logic       a_write, a_valid, b_write, b_valid;

  logic       a_ready, b_ready, a_rsp_valid, b_rsp_valid;
  logic [7:0] a_rsp_data, b_rsp_data;
  logic [7:0] ram_addr, ram_data, ram_rdata;
  logic       ram_write, ram_valid;

  logic       fa_ready, fb_ready, fa_rsp_valid, fb_rsp_valid;
  logic [7:0] fa_rsp_data, fb_rsp_data;
  logic [7:0] fram_addr, fram_data, fram_rdata;
  logic       fram_write, fram_valid;

  logic [7:0] mem0 [256];
  logic [7:0] mem1 [256];
  logic [7:0] ref_mem [256];

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  typedef struct {
    logic       id;
    logic [7:0] data;
    int         due;
  } rsp_t;
  rsp_t sbq[$];

  typedef struct {
    logic       av, aw;
    logic [7:0] aa, ad;
    logic       bv, bw;
    logic [7:0] ba, bd;
    logic       ea, eb;
    logic [7:0] eaddr;
    logic       ew;
  } vec_t;
  vec_t vecs[12];

  ram_arbiter #(.ADDR_W(8), .DATA_W(8), .FIXED_PRIO(0)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_a_addr(a_addr), .i_a_data(a_data), .i_a_write(a_write), .i_a_valid(a_valid),
    .o_a_ready(a_ready), .o_a_rsp_data(a_rsp_data), .o_a_rsp_valid(a_rsp_valid),
    .i_b_addr(b_addr), .i_b_data(b_data), .i_b_write(b_write), .i_b_valid(b_valid),
    .o_b_ready(b_ready), .o_b_rsp_data(b_rsp_data), .o_b_rsp_valid(b_rsp_valid),
    .o_ram_addr(ram_addr), .o_ram_data(ram_data), .o_ram_write(ram_write),
    .o_ram_valid(ram_valid), .i_ram_rsp_data(ram_rdata)
  );

  ram_arbiter #(.ADDR_W(8), .DATA_W(8), .FIXED_PRIO(1)) dut_f (
    .i_clk(clk), .i_rst(rst),
    .i_a_addr(a_addr), .i_a_data(a_data), .i_a_write(a_write), .i_a_valid(a_valid),
    .o_a_ready(fa_ready), .o_a_rsp_data(fa_rsp_data), .o_a_rsp_valid(fa_rsp_valid),
    .i_b_addr(b_addr), .i_b_data(b_data), .i_b_write(b_write), .i_b_valid(b_valid),
    .o_b_ready(fb_ready), .o_b_rsp_data(fb_rsp_data), .o_b_rsp_valid(fb_rsp_valid),
    .o_ram_addr(fram_addr), .o_ram_data(fram_data), .o_ram_write(fram_write),
    .o_ram_valid(fram_valid), .i_ram_rsp_data(fram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered-output single-port RAM models, one per DUT.
  always @(posedge clk) begin
    if (ram_valid) begin
      if (ram_write) mem0[ram_addr] <= ram_data;
      else           ram_rdata <= mem0[ram_addr];
    end
    if (fram_valid) begin
      if (fram_write) mem1[fram_addr] <= fram_data;
      else            fram_rdata <= mem1[fram_addr];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Called once per cycle in the sampling window: checks responses due now,
  // then records the read expected from this cycle's grant.
  task automatic sb_step(input logic rd, input logic id, input logic [7:0] addr,
                         input logic wr, input logic [7:0] wdata);
    rsp_t e;
    if (rst) begin
      sbq.delete();
      chk("rst_a_rsp_valid", a_rsp_valid, 0);
      chk("rst_b_rsp_valid", b_rsp_valid, 0);
      chk("rst_a_rsp_data", a_rsp_data, 0);
      chk("rst_b_rsp_data", b_rsp_data, 0);
    end else begin
      if (sbq.size() > 0 && sbq[0].due == cyc) begin
        e = sbq.pop_front();
        chk(e.id ? "b_rsp_valid" : "a_rsp_valid", e.id ? b_rsp_valid : a_rsp_valid, 1);
        chk(e.id ? "b_rsp_data" : "a_rsp_data", e.id ? b_rsp_data : a_rsp_data, e.data);
        chk(e.id ? "a_rsp_valid_idle" : "b_rsp_valid_idle", e.id ? a_rsp_valid : b_rsp_valid, 0);
      end else begin
        chk("a_rsp_valid_none", a_rsp_valid, 0);
        chk("b_rsp_valid_none", b_rsp_valid, 0);
      end
      if (rd) sbq.push_back('{id: id, data: ref_mem[addr], due: cyc + 1});
      if (wr) ref_mem[addr] = wdata;
    end
    chk("fixed_b_rsp_valid", fb_rsp_valid, 0);
    @(posedge clk);
    cyc++;
    #1;
  endtask

  function automatic vec_t mk(input logic av, aw, input logic [7:0] aa, ad,
                              input logic bv, bw, input logic [7:0] ba, bd,
                              input logic ea, eb, input logic [7:0] eaddr, input logic ew);
    vec_t v;
    v.av = av; v.aw = aw; v.aa = aa; v.ad = ad;
    v.bv = bv; v.bw = bw; v.ba = ba; v.bd = bd;
    v.ea = ea; v.eb = eb; v.eaddr = eaddr; v.ew = ew;
    return v;
  endfunction

  task automatic drive(input logic av, aw, input logic [7:0] aa, ad,
                       input logic bv, bw, input logic [7:0] ba, bd);
    a_valid = av; a_write = aw; a_addr = aa; a_data = ad;
    b_valid = bv; b_write = bw; b_addr = ba; b_data = bd;
  endtask

  initial begin
    logic [7:0] exp_wdata;
    for (int i = 0; i < 256; i++) begin
      mem0[i] = 8'(i) ^ 8'hA5;
      mem1[i] = 8'(i) ^ 8'hA5;
      ref_mem[i] = 8'(i) ^ 8'hA5;
    end
    ram_rdata = 8'h00;
    fram_rdata = 8'h00;
    rst = 1'b1;
    drive(1, 0, 8'h10, 0, 1, 0, 8'h20, 0);
    @(posedge clk);
    #1;
    // Reset: requests present but nothing accepted.
    #3;
    chk("rst_a_ready", a_ready, 0);
    chk("rst_b_ready", b_ready, 0);
    chk("rst_ram_valid", ram_valid, 0);
    chk("rst_ram_addr", ram_addr, 0);
    sb_step(0, 0, 0, 0, 0);
    #3;
    sb_step(0, 0, 0, 0, 0);
    rst = 1'b0;

    vecs[0]  = mk(1, 1, 8'h10, 8'h5A, 0, 0, 8'h00, 8'h00, 1, 0, 8'h10, 1);
    vecs[1]  = mk(1, 0, 8'h10, 8'h00, 0, 0, 8'h00, 8'h00, 1, 0, 8'h10, 0);
    vecs[2]  = mk(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 0);
    vecs[3]  = mk(1, 0, 8'h10, 8'h00, 1, 0, 8'h20, 8'h00, 1, 0, 8'h10, 0);
    vecs[4]  = mk(1, 0, 8'h10, 8'h00, 1, 0, 8'h20, 8'h00, 0, 1, 8'h20, 0);
    vecs[5]  = mk(1, 0, 8'h10, 8'h00, 1, 0, 8'h20, 8'h00, 1, 0, 8'h10, 0);
    vecs[6]  = mk(1, 0, 8'h10, 8'h00, 1, 0, 8'h20, 8'h00, 0, 1, 8'h20, 0);
    vecs[7]  = mk(1, 0, 8'h10, 8'h00, 1, 0, 8'h20, 8'h00, 1, 0, 8'h10, 0);
    vecs[8]  = mk(1, 0, 8'hFF, 8'h00, 1, 1, 8'hFF, 8'h33, 0, 1, 8'hFF, 1);
    vecs[9]  = mk(1, 0, 8'hFF, 8'h00, 0, 0, 8'h00, 8'h00, 1, 0, 8'hFF, 0);
    vecs[10] = mk(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 0);
    vecs[11] = mk(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 0);

    for (int i = 0; i < 12; i++) begin
      drive(vecs[i].av, vecs[i].aw, vecs[i].aa, vecs[i].ad,
            vecs[i].bv, vecs[i].bw, vecs[i].ba, vecs[i].bd);
      #3;
      exp_wdata = vecs[i].ea ? vecs[i].ad : (vecs[i].eb ? vecs[i].bd : 8'h00);
      chk($sformatf("v%0d_a_ready", i), a_ready, vecs[i].ea);
      chk($sformatf("v%0d_b_ready", i), b_ready, vecs[i].eb);
      chk($sformatf("v%0d_ram_valid", i), ram_valid, vecs[i].ea | vecs[i].eb);
      chk($sformatf("v%0d_ram_addr", i), ram_addr, vecs[i].eaddr);
      chk($sformatf("v%0d_ram_write", i), ram_write, vecs[i].ew);
      chk($sformatf("v%0d_ram_data", i), ram_data, exp_wdata);
      chk($sformatf("v%0d_fixed_a_ready", i), fa_ready, vecs[i].av);
      chk($sformatf("v%0d_fixed_b_ready", i), fb_ready, vecs[i].bv & ~vecs[i].av);
      sb_step((vecs[i].ea | vecs[i].eb) & ~vecs[i].ew, vecs[i].eb, vecs[i].eaddr,
              (vecs[i].ea | vecs[i].eb) & vecs[i].ew, exp_wdata);
    end

    // Idle: response data holds, RAM port quiet.
    #3;
    chk("hold_a_rsp_data", a_rsp_data, 8'h33);
    chk("hold_b_rsp_data", b_rsp_data, 8'h20 ^ 8'hA5);
    chk("idle_ram_valid", ram_valid, 0);
    chk("idle_ram_addr", ram_addr, 0);
    sb_step(0, 0, 0, 0, 0);

    // Move pointer to B with a contended cycle (A wins).
    drive(1, 0, 8'h11, 0, 1, 0, 8'h21, 0);
    #3;
    chk("pre_rst_a_ready", a_ready, 1);
    sb_step(1, 0, 8'h11, 0, 0);
    // A read accepted alone.
    drive(1, 0, 8'h12, 0, 0, 0, 8'h00, 0);
    #3;
    chk("acc_a_ready", a_ready, 1);
    sb_step(1, 0, 8'h12, 0, 0);
    // Reset on the next edge: pending read dropped, request not accepted.
    rst = 1'b1;
    drive(1, 0, 8'h13, 0, 1, 0, 8'h23, 0);
    #3;
    chk("mid_rst_a_ready", a_ready, 0);
    chk("mid_rst_b_ready", b_ready, 0);
    chk("mid_rst_ram_valid", ram_valid, 0);
    sb_step(0, 0, 0, 0, 0);
    rst = 1'b0;
    // First contended cycle after reset grants A.
    #3;
    chk("post_rst_a_ready", a_ready, 1);
    chk("post_rst_b_ready", b_ready, 0);
    chk("post_rst_ram_addr", ram_addr, 8'h13);
    chk("post_rst_fixed_a_ready", fa_ready, 1);
    sb_step(1, 0, 8'h13, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      #3;
      sb_step(0, 0, 0, 0, 0);
    end
    chk("sb_drained", sbq.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
